dmem_access_ctrl: RTL and testbench



---
 rtl/dmem_access_ctrl_if.sv | 37 +++
 rtl/dmem_access_ctrl.sv | 149 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_if.sv
// Request/response and data-memory bus of the data memory access controller.
// slave = controller side, master = datapath plus memory side.
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] req_offset;
  logic [15:0]       req_wdata;
  logic              resp_valid;
  logic [15:0]       resp_rdata;
  logic              resp_err;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [15:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_base,
    input  req_offset, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output resp_err, busy, mem_addr,
    output mem_wdata, mem_write, mem_read
  );

  modport master (
    output req_valid, req_we, req_base,
    output req_offset, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err, busy, mem_addr,
    input  mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data memory access controller: one request at a time, fully registered outputs.
// Define DMEM_WRITE_VERIFY_EN to add a read-back check after every store.
module dmem_access_ctrl #(
  parameter int SIZE_DM = 32,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_access_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    ERR
`ifdef DMEM_WRITE_VERIFY_EN
    ,
    VSTROBE,
    VCHECK
`endif
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              rv_q, rv_d;
  logic              err_q, err_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  logic [ADDR_W-1:0] ea;
  logic              oor;

  // Effective address wraps modulo 2^ADDR_W
  assign ea  = bus.req_base + bus.req_offset;
  assign oor = 32'(ea) >= SIZE_DM;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    rv_d    = 1'b0;
    err_d   = 1'b0;
    rdata_d = 16'h0000;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (oor) begin
            state_d = ERR;
            rv_d    = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = SETUP;
            we_d    = bus.req_we;
            addr_d  = ea;
            if (bus.req_we) wdata_d = bus.req_wdata;
          end
        end
      end
      SETUP: begin
        state_d = STROBE;
        wr_d    = we_q;
        rd_d    = !we_q;
      end
      STROBE: begin
        state_d = HOLD;
`ifdef DMEM_WRITE_VERIFY_EN
        rv_d    = !we_q;
`else
        rv_d    = 1'b1;
`endif
        rdata_d = we_q ? 16'h0000 : bus.mem_rdata;
      end
      HOLD: begin
`ifdef DMEM_WRITE_VERIFY_EN
        if (we_q) begin
          state_d = VSTROBE;
          rd_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
`ifdef DMEM_WRITE_VERIFY_EN
      VSTROBE: begin
        state_d = VCHECK;
        rv_d    = 1'b1;
        rdata_d = bus.mem_rdata;
        err_d   = bus.mem_rdata != wdata_q;
      end
      VCHECK: state_d = IDLE;
`endif
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d  = state_d != IDLE;
    ready_d = state_d == IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 16'h0000;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = rv_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.busy       = busy_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_write  = wr_q;
  assign bus.mem_read   = rd_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: vector table, corner sequences, random vs reference model.
// Build with DMEM_WRITE_VERIFY_EN to exercise the store read-back path.
module tb_dmem_access_ctrl;
  localparam int SIZE_DM = 32;
  localparam int ADDR_W  = 8;
`ifdef DMEM_WRITE_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_access_ctrl #(
    .SIZE_DM(SIZE_DM),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int nvec = 0;
  int nmis = 0;
  logic [15:0] mem     [SIZE_DM];
  logic [15:0] ref_mem [SIZE_DM];
  bit stuck0 = 1'b0;

  // Level-sensitive memory with combinational read; reset loads known contents
  assign bus.mem_rdata = (32'(bus.mem_addr) < SIZE_DM) ?
                         mem[bus.mem_addr[4:0]] : 16'h0000;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE_DM; i++) mem[i] <= 16'h1000 + 16'(i);
    end else if (bus.mem_write && 32'(bus.mem_addr) < SIZE_DM) begin
      mem[bus.mem_addr[4:0]] <= stuck0 ? (bus.mem_wdata & 16'hFFFE)
                                       : bus.mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus rules: strobes exclusive, address/data steady around a strobe
  logic [7:0]  prev_addr;
  logic [15:0] prev_wd;
  bit          prev_stb = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stb = 1'b0;
    end else begin
      chk("rw_exclusive", 32'(bus.mem_read && bus.mem_write), 0);
      if (bus.mem_read || bus.mem_write || prev_stb) begin
        chk("addr_stable", 32'(bus.mem_addr), 32'(prev_addr));
        chk("wdata_stable", 32'(bus.mem_wdata), 32'(prev_wd));
      end
      prev_stb  = bus.mem_read || bus.mem_write;
      prev_addr = bus.mem_addr;
      prev_wd   = bus.mem_wdata;
    end
  end

  task automatic do_req(input bit we, input logic [7:0] b, input logic [7:0] o,
                        input logic [15:0] wd, output int lat,
                        output logic err, output logic [15:0] rd,
                        output logic [7:0] rds, output logic [7:0] wrs,
                        output int nresp);
    int w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 32'(bus.req_ready), 1);
    bus.req_we     = we;
    bus.req_base   = b;
    bus.req_offset = o;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_base   = ~b;
    bus.req_wdata  = ~wd;
    lat = 0; err = 1'b0; rd = 16'h0; rds = 8'h0; wrs = 8'h0; nresp = 0;
    for (int k = 1; k < 8; k++) begin
      if (k > 1) @(negedge clk);
      rds[k] = bus.mem_read;
      wrs[k] = bus.mem_write;
      if (bus.resp_valid) begin
        nresp++;
        if (lat == 0) begin
          lat = k;
          err = bus.resp_err;
          rd  = bus.resp_rdata;
        end
      end
    end
  endtask

  task automatic run_check(input string p, input bit we, input logic [7:0] b,
                           input logic [7:0] o, input logic [15:0] wd,
                           input bit oor, input bit exp_err,
                           input logic [15:0] exp_rd);
    int lat, nresp;
    logic err;
    logic [15:0] rd;
    logic [7:0] rds, wrs;
    int exp_lat;
    logic [7:0] exp_rds, exp_wrs;
    exp_lat = oor ? 1 : ((we && VER) ? 5 : 3);
    exp_wrs = (!oor && we) ? 8'h04 : 8'h00;
    exp_rds = oor ? 8'h00 : (we ? (VER ? 8'h10 : 8'h00) : 8'h04);
    do_req(we, b, o, wd, lat, err, rd, rds, wrs, nresp);
    chk({p, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({p, "_nresp"}, 32'(nresp), 1);
    chk({p, "_err"}, 32'(err), 32'(exp_err));
    chk({p, "_rdata"}, 32'(rd), 32'(exp_rd));
    chk({p, "_rd_strobe"}, 32'(rds), 32'(exp_rds));
    chk({p, "_wr_strobe"}, 32'(wrs), 32'(exp_wrs));
  endtask

  typedef struct {
    bit          we;
    logic [7:0]  b;
    logic [7:0]  o;
    logic [15:0] wd;
    bit          err;
    logic [15:0] rd;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, nr, ea;
    bit we, oor;
    logic [7:0] b, o;
    logic [15:0] wd, erd;

    tbl[0]  = '{1'b1, 8'd4,   8'd1,   16'hBEEF, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 8'd5,   8'd0,   16'h0000, 1'b0, 16'hBEEF};
    tbl[2]  = '{1'b0, 8'h02,  8'hFE,  16'h0000, 1'b0, 16'h1000};
    tbl[3]  = '{1'b0, 8'd30,  8'd2,   16'h0000, 1'b1, 16'h0000};
    tbl[4]  = '{1'b1, 8'd31,  8'd0,   16'hCAFE, 1'b0, 16'h0000};
    tbl[5]  = '{1'b0, 8'h20,  8'hFF,  16'h0000, 1'b0, 16'hCAFE};
    tbl[6]  = '{1'b1, 8'h80,  8'h00,  16'h1111, 1'b1, 16'h0000};
    tbl[7]  = '{1'b0, 8'h00,  8'hFF,  16'h0000, 1'b1, 16'h0000};
    tbl[8]  = '{1'b0, 8'd31,  8'd1,   16'h0000, 1'b1, 16'h0000};
    tbl[9]  = '{1'b1, 8'hFF,  8'h01,  16'h5A5A, 1'b0, 16'h0000};
    tbl[10] = '{1'b0, 8'h10,  8'hF0,  16'h0000, 1'b0, 16'h5A5A};

    for (int i = 0; i < SIZE_DM; i++) ref_mem[i] = 16'h1000 + 16'(i);
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    bus.req_base = 8'h0; bus.req_offset = 8'h0; bus.req_wdata = 16'h0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_resp_rdata", 32'(bus.resp_rdata), 0);
    chk("rst_resp_err", 32'(bus.resp_err), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_strobes", 32'({bus.mem_read, bus.mem_write}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during a write strobe
    bus.req_we = 1'b1; bus.req_base = 8'd10; bus.req_offset = 8'd0;
    bus.req_wdata = 16'hAAAA; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mr_setup_addr", 32'(bus.mem_addr), 10);
    chk("mr_setup_wr", 32'(bus.mem_write), 0);
    @(negedge clk);
    chk("mr_strobe_wr", 32'(bus.mem_write), 1);
    #2 rst_n = 1'b0;
    #1 chk("mr_async_wr_drop", 32'(bus.mem_write), 0);
    chk("mr_async_busy", 32'(bus.busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nr = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.resp_valid) nr++;
      @(negedge clk);
    end
    chk("mr_no_resp", 32'(nr), 0);
    chk("mr_ready", 32'(bus.req_ready), 1);

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      erd = tbl[i].rd;
      if (VER && tbl[i].we && !tbl[i].err) erd = tbl[i].wd;
      ea = (int'(tbl[i].b) + int'(tbl[i].o)) % 256;
      if (tbl[i].we && !tbl[i].err) ref_mem[ea] = tbl[i].wd;
      run_check($sformatf("tbl%0d", i), tbl[i].we, tbl[i].b, tbl[i].o,
                tbl[i].wd, tbl[i].err, tbl[i].err, erd);
    end

    // Request held valid across busy periods
    bus.req_we = 1'b0; bus.req_base = 8'd1; bus.req_offset = 8'd0;
    bus.req_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.req_ready) acc++;
      chk("tp_ready_vs_busy", 32'(bus.req_ready), 32'(!bus.busy));
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("tp_accepts", 32'(acc), 3);
    repeat (6) @(negedge clk);

    // Random requests against the reference memory model
    for (int i = 0; i < 40; i++) begin
      we  = 1'($urandom_range(0, 1));
      b   = 8'($urandom_range(0, 40));
      o   = 8'($urandom_range(0, 19)) - 8'd8;
      wd  = 16'($urandom);
      ea  = (int'(b) + int'(o)) % 256;
      oor = ea >= SIZE_DM;
      if (oor) erd = 16'h0;
      else if (we) erd = VER ? wd : 16'h0;
      else erd = ref_mem[ea];
      if (we && !oor) ref_mem[ea] = wd;
      run_check($sformatf("rnd%0d", i), we, b, o, wd, oor, oor, erd);
    end

`ifdef DMEM_WRITE_VERIFY_EN
    // Stuck-at-0 bit 0 makes the read-back disagree
    stuck0 = 1'b1;
    run_check("verify_stuck", 1'b1, 8'd3, 8'd0, 16'h0001,
              1'b0, 1'b1, 16'h0000);
    stuck0 = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
